// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: bus widths and the shared-port arbiter state encoding.
package cpu_bus_pkg;

  localparam int BUS_W  = 32;
  localparam int STRB_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    D_REQ  = 3'd1,
    D_WAIT = 3'd2,
    I_REQ  = 3'd3,
    I_WAIT = 3'd4
  } arb_state_t;

endpackage

// File: rtl/sram_like_arbiter.sv
// Arbitrates fetch and mem-stage accesses onto one SRAM-like port, one transaction at a time,
// and turns the per-side completion flags into pipeline stall signals.
module sram_like_arbiter
  import cpu_bus_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [BUS_W-1:0]  inst_addr,
  output logic [BUS_W-1:0]  inst_rdata,
  output logic              i_stall,
  input  logic              data_req,
  input  logic [STRB_W-1:0] data_wen,
  input  logic [BUS_W-1:0]  data_addr,
  input  logic [BUS_W-1:0]  data_wdata,
  output logic [BUS_W-1:0]  data_rdata,
  output logic              d_stall,
  input  logic              div_stall,
  output logic              longest_stall,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [STRB_W-1:0] mem_wstrb,
  output logic [BUS_W-1:0]  mem_addr,
  output logic [BUS_W-1:0]  mem_wdata,
  input  logic [BUS_W-1:0]  mem_rdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok
);

  arb_state_t        r_state;
  logic              r_iDone;
  logic              r_dDone;
  logic              r_memReq;
  logic [BUS_W-1:0]  r_instRdata;
  logic [BUS_W-1:0]  r_dataRdata;

  logic w_iPending;
  logic w_dPending;
  logic w_longestStall;
  logic w_isWrite;

  assign w_iPending     = inst_req & ~r_iDone;
  assign w_dPending     = data_req & ~r_dDone;
  assign w_longestStall = w_iPending | w_dPending | div_stall;
  assign w_isWrite      = |data_wen;

  assign i_stall       = w_iPending;
  assign d_stall       = w_dPending;
  assign longest_stall = w_longestStall;
  assign inst_rdata    = r_instRdata;
  assign data_rdata    = r_dataRdata;
  assign mem_req       = r_memReq;

  // The done flags clear when the pipeline advances; a completion on the same edge takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_iDone     <= 1'b0;
      r_dDone     <= 1'b0;
      r_memReq    <= 1'b0;
      r_instRdata <= '0;
      r_dataRdata <= '0;
    end else begin
      if (!w_longestStall) begin
        r_iDone <= 1'b0;
        r_dDone <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_dPending) begin
            r_state  <= D_REQ;
            r_memReq <= 1'b1;
          end else if (w_iPending) begin
            r_state  <= I_REQ;
            r_memReq <= 1'b1;
          end
        end
        D_REQ: begin
          if (mem_addr_ok) begin
            r_state  <= D_WAIT;
            r_memReq <= 1'b0;
          end
        end
        D_WAIT: begin
          if (mem_data_ok) begin
            r_dDone <= 1'b1;
            if (!w_isWrite) begin
              r_dataRdata <= mem_rdata;
            end
            if (w_iPending) begin
              r_state  <= I_REQ;
              r_memReq <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        I_REQ: begin
          if (mem_addr_ok) begin
            r_state  <= I_WAIT;
            r_memReq <= 1'b0;
          end
        end
        I_WAIT: begin
          if (mem_data_ok) begin
            r_iDone     <= 1'b1;
            r_instRdata <= mem_rdata;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_memReq <= 1'b0;
        end
      endcase
    end
  end

  // Request fields follow the requester's held inputs and read as zero whenever the port is idle.
  always_comb begin
    mem_wr    = 1'b0;
    mem_wstrb = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      D_REQ: begin
        mem_wr    = w_isWrite;
        mem_wstrb = data_wen;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end
      I_REQ: begin
        mem_addr = inst_addr;
      end
      default: begin
        mem_wr = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with a small SRAM-like memory responder.
module tb_sram_like_arbiter;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        i_stall;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        d_stall;
  logic        div_stall;
  logic        longest_stall;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;

  int errors = 0;
  int checks = 0;

  int          addrDelay  = 0;
  int          dataDelay  = 2;
  bit          memManual  = 1'b0;
  logic        manAddrOk  = 1'b0;
  logic        manDataOk  = 1'b0;
  logic [31:0] manRdata   = 32'h0;
  int          acceptCount = 0;
  logic [31:0] acceptAddr[$];
  logic        lastWr     = 1'b0;
  logic [3:0]  lastStrb   = 4'h0;
  logic [31:0] lastAddr   = 32'h0;
  logic [31:0] lastWdata  = 32'h0;

  sram_like_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_rdata   (inst_rdata),
    .i_stall      (i_stall),
    .data_req     (data_req),
    .data_wen     (data_wen),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_rdata   (data_rdata),
    .d_stall      (d_stall),
    .div_stall    (div_stall),
    .longest_stall(longest_stall),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] memLookup(input logic [31:0] a);
    case (a)
      32'hBFC00000: return 32'h3C1D0001;
      32'hBFC00004: return 32'h27BD0010;
      32'hBFC00008: return 32'h8C880000;
      32'h80001000: return 32'h12345678;
      default:      return 32'hDEADBEEF;
    endcase
  endfunction

  // Memory responder: handshakes are decided on the falling edge and sampled by the DUT on the next rising edge.
  initial begin
    int phase = 0;
    int cnt = 0;
    logic [31:0] pendAddr = 32'h0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h0;
    forever begin
      @(negedge clk);
      if (memManual) begin
        mem_addr_ok = manAddrOk;
        mem_data_ok = manDataOk;
        mem_rdata   = manRdata;
        phase = 0;
        cnt = 0;
      end else if (rst) begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        phase = 0;
        cnt = 0;
      end else begin
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        if (phase == 2) phase = 0;
        if (phase == 0) begin
          if (mem_req) begin
            if (cnt >= addrDelay) begin
              mem_addr_ok = 1'b1;
              phase = 1;
              cnt = 0;
              acceptCount++;
              pendAddr = mem_addr;
              acceptAddr.push_back(mem_addr);
              lastWr    = mem_wr;
              lastStrb  = mem_wstrb;
              lastAddr  = mem_addr;
              lastWdata = mem_wdata;
            end else begin
              cnt++;
            end
          end
        end else if (phase == 1) begin
          if (cnt >= dataDelay) begin
            mem_data_ok = 1'b1;
            mem_rdata   = memLookup(pendAddr);
            phase = 2;
            cnt = 0;
          end else begin
            cnt++;
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = 32'h0;
    data_req = 1'b0; data_wen = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    div_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req got=%b exp=0", mem_req); end
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_rdata got=%h exp=0", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_data_rdata got=%h exp=0", data_rdata); end
    checks++; if (longest_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_longest_stall got=%b exp=0", longest_stall); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_mem_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_fetch_only();
    int start = acceptCount;
    bit seen = 1'b0;
    logic prevStall;
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    #0;
    prevStall = i_stall;
    checks++; if (i_stall !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_rise got=%b exp=1", i_stall); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_data_ok) begin
        seen = 1'b1;
        checks++; if (prevStall !== 1'b1) begin errors++; $display("[TB] FAIL fetch_stall_before_ok got=%b exp=1", prevStall); end
        checks++; if (i_stall !== 1'b0) begin errors++; $display("[TB] FAIL fetch_stall_after_ok got=%b exp=0", i_stall); end
        break;
      end
      prevStall = i_stall;
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL fetch_timeout got=no_data_ok exp=data_ok"); end
    inst_req = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++; if (acceptCount - start !== 1) begin errors++; $display("[TB] FAIL fetch_req_count got=%0d exp=1", acceptCount - start); end
    checks++; if (inst_rdata !== 32'h3C1D0001) begin errors++; $display("[TB] FAIL fetch_rdata got=%h exp=3c1d0001", inst_rdata); end
  endtask

  task automatic test_simultaneous();
    int dFall = -1;
    int iFall = -1;
    acceptAddr.delete();
    data_req = 1'b1; data_wen = 4'h0; data_addr = 32'h80001000;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dFall < 0 && !d_stall) begin
        dFall = i;
        if (i_stall) begin
          checks++; if (longest_stall !== 1'b1) begin errors++; $display("[TB] FAIL simul_longest_held got=%b exp=1", longest_stall); end
        end
      end
      if (iFall < 0 && !i_stall) iFall = i;
      if (dFall >= 0 && iFall >= 0) break;
    end
    checks++; if (dFall < 0 || iFall < 0) begin errors++; $display("[TB] FAIL simul_timeout got=d%0d_i%0d exp=both_done", dFall, iFall); end
    checks++; if (!(dFall < iFall)) begin errors++; $display("[TB] FAIL simul_order got=d%0d_i%0d exp=data_first", dFall, iFall); end
    checks++; if (longest_stall !== 1'b0) begin errors++; $display("[TB] FAIL simul_release got=%b exp=0", longest_stall); end
    data_req = 1'b0; inst_req = 1'b0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if (acceptAddr.size() != 2) begin
      errors++; $display("[TB] FAIL simul_accepts got=%0d exp=2", acceptAddr.size());
    end else if (acceptAddr[0] !== 32'h80001000 || acceptAddr[1] !== 32'hBFC00004) begin
      errors++; $display("[TB] FAIL simul_addr_order got=%h,%h exp=80001000,bfc00004", acceptAddr[0], acceptAddr[1]);
    end
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL simul_data_rdata got=%h exp=12345678", data_rdata); end
    checks++; if (inst_rdata !== 32'h27BD0010) begin errors++; $display("[TB] FAIL simul_inst_rdata got=%h exp=27bd0010", inst_rdata); end
  endtask

  task automatic test_byte_store();
    bit done = 1'b0;
    data_req = 1'b1; data_wen = 4'b0010; data_addr = 32'h80000002; data_wdata = 32'h0000AB00;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!d_stall) begin done = 1'b1; break; end
    end
    data_req = 1'b0; data_wen = 4'h0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL store_timeout got=stalled exp=done"); end
    checks++; if (lastWr !== 1'b1) begin errors++; $display("[TB] FAIL store_mem_wr got=%b exp=1", lastWr); end
    checks++; if (lastStrb !== 4'b0010) begin errors++; $display("[TB] FAIL store_wstrb got=%b exp=0010", lastStrb); end
    checks++; if (lastAddr !== 32'h80000002) begin errors++; $display("[TB] FAIL store_addr got=%h exp=80000002", lastAddr); end
    checks++; if (lastWdata !== 32'h0000AB00) begin errors++; $display("[TB] FAIL store_wdata got=%h exp=0000ab00", lastWdata); end
    repeat (2) @(posedge clk); #1;
    checks++; if (data_rdata !== 32'h12345678) begin errors++; $display("[TB] FAIL store_rdata_kept got=%h exp=12345678", data_rdata); end
  endtask

  task automatic test_div_overlap();
    int start = acceptCount;
    div_stall = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC00008;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (longest_stall !== 1'b1) begin errors++; $display("[TB] FAIL div_longest_c%0d got=%b exp=1", i, longest_stall); end
    end
    checks++; if (i_stall !== 1'b0) begin errors++; $display("[TB] FAIL div_done_held got=%b exp=0", i_stall); end
    checks++; if (acceptCount - start !== 1) begin errors++; $display("[TB] FAIL div_fetch_count got=%0d exp=1", acceptCount - start); end
    checks++; if (inst_rdata !== 32'h8C880000) begin errors++; $display("[TB] FAIL div_inst_rdata got=%h exp=8c880000", inst_rdata); end
    div_stall = 1'b0;
    #1;
    checks++; if (longest_stall !== 1'b0) begin errors++; $display("[TB] FAIL div_release got=%b exp=0", longest_stall); end
    @(posedge clk); #1;
    checks++; if (i_stall !== 1'b1) begin errors++; $display("[TB] FAIL div_done_cleared got=%b exp=1", i_stall); end
    inst_req = 1'b0;
    repeat (4) @(posedge clk); #1;
    checks++; if (acceptCount - start !== 1) begin errors++; $display("[TB] FAIL div_no_refetch got=%0d exp=1", acceptCount - start); end
  endtask

  task automatic test_backpressure();
    int reqCycles = 0;
    bit done = 1'b0;
    addrDelay = 5; dataDelay = 1;
    data_req = 1'b1; data_wen = 4'hF; data_addr = 32'h80002000; data_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        reqCycles++;
        checks++;
        if ({mem_addr, mem_wdata} !== {32'h80002000, 32'hCAFEF00D}) begin
          errors++; $display("[TB] FAIL bp_stable_c%0d got=%h/%h exp=80002000/cafef00d", i, mem_addr, mem_wdata);
        end
      end
      if (!d_stall) begin done = 1'b1; break; end
    end
    data_req = 1'b0; data_wen = 4'h0;
    checks++; if (!done) begin errors++; $display("[TB] FAIL bp_timeout got=stalled exp=done"); end
    checks++; if (reqCycles !== 6) begin errors++; $display("[TB] FAIL bp_req_cycles got=%0d exp=6", reqCycles); end
    addrDelay = 0; dataDelay = 2;
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    memManual = 1'b1; manAddrOk = 1'b0; manDataOk = 1'b0; manRdata = 32'h0;
    inst_req = 1'b1; inst_addr = 32'hBFC0000C;
    @(posedge clk); #1;
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'hBFC0000C) begin errors++; $display("[TB] FAIL rstmid_issue got=%b/%h exp=1/bfc0000c", mem_req, mem_addr); end
    manAddrOk = 1'b1;
    @(posedge clk); #1;
    manAddrOk = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wait_req got=%b exp=0", mem_req); end
    rst = 1'b1;
    #1;
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_inst_rdata got=%h exp=0", inst_rdata); end
    checks++; if (data_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_data_rdata got=%h exp=0", data_rdata); end
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || mem_wr !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_port got=%b/%h/%b exp=0/0/0", mem_req, mem_addr, mem_wr); end
    inst_req = 1'b0;
    #1;
    checks++; if (longest_stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_longest got=%b exp=0", longest_stall); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    manDataOk = 1'b1; manRdata = 32'h55555555;
    @(posedge clk); #1;
    manDataOk = 1'b0;
    @(posedge clk); #1;
    checks++; if (inst_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_stray_ok got=%h exp=0", inst_rdata); end
    checks++; if (mem_req !== 1'b0 || i_stall !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_idle got=%b/%b exp=0/0", mem_req, i_stall); end
    memManual = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_simultaneous();
    test_byte_store();
    test_div_overlap();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

Interface
REQ-001 SHALL have the ports listed below; clock and reset come first. There is one clock, and reset is asynchronous and active-high.
- clk  in  1  core clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch stage requests the word at inst_addr (level).
- inst_addr  in  32  fetch address (pcF).
- inst_rdata  out  32  registered fetched word.
- i_stall  out  1  fetch not yet served this pipeline cycle.
- data_req  in  1  mem stage requests an access (data_sram_enM).
- data_wen  in  4  byte write enables; 0 means read.
- data_addr  in  32  data address (aluoutM).
- data_wdata  in  32  write data.
- data_rdata  out  32  registered load word.
- d_stall  out  1  data access not yet served this pipeline cycle.
- div_stall  in  1  divider busy.
- longest_stall  out  1  global pipeline freeze.
- mem_req  out  1  shared-port request.
- mem_wr  out  1  shared-port write.
- mem_wstrb  out  4  shared-port byte strobes.
- mem_addr  out  32  shared-port address.
- mem_wdata  out  32  shared-port write data.
- mem_rdata  in  32  shared-port read data.
- mem_addr_ok  in  1  address accepted.
- mem_data_ok  in  1  data returned or write done.

Function
REQ-002 SHALL use these FSM states: IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT. At most one transaction is outstanding on the shared port.
REQ-003 SHALL make these transitions from IDLE:
- data_req & ~d_done goes to D_REQ.
- Otherwise, inst_req & ~i_done goes to I_REQ.
- Otherwise, stay in IDLE.
- When both requests are pending, data wins.
REQ-004 SHALL, in D_REQ, assert mem_req with mem_wr=|data_wen, mem_wstrb=data_wen, mem_addr=data_addr and mem_wdata=data_wdata. These are held stable until mem_addr_ok is sampled high, then the FSM goes to D_WAIT.
REQ-005 SHALL, in D_WAIT on mem_data_ok, do the following:
- Set d_done.
- For a read only, load data_rdata from mem_rdata.
- Go to I_REQ if inst_req & ~i_done, else go to IDLE.
REQ-006 SHALL, in I_REQ, assert mem_req with mem_wr=0, mem_wstrb=0 and mem_addr=inst_addr. On mem_addr_ok the FSM goes to I_WAIT.
REQ-007 SHALL, in I_WAIT on mem_data_ok, load inst_rdata from mem_rdata, set i_done, and go to IDLE.
REQ-008 SHALL compute i_stall = inst_req & ~i_done and d_stall = data_req & ~d_done, combinationally.
REQ-009 SHALL compute longest_stall = i_stall | d_stall | div_stall, combinationally.
REQ-010 SHALL clear i_done and d_done on the edge where longest_stall=0. Each side is therefore served at most once per pipeline advance.
REQ-011 SHALL keep i_done and d_done set while div_stall=1, so no access is repeated during a divide.
REQ-012 SHALL drop each stall exactly one cycle after its mem_data_ok is sampled.
REQ-013 SHALL hold inst_rdata and data_rdata at their last captured values until the next capture. Writes never modify data_rdata.
REQ-014 SHALL ignore mem_data_ok in IDLE, D_REQ and I_REQ, and ignore mem_addr_ok in the WAIT states.
REQ-015 SHALL never abort a transaction once mem_req has been asserted. Requesters keep their inputs stable while their stall is high.
REQ-016 SHALL keep mem_req low in IDLE and in both WAIT states.

Reset
REQ-017 SHALL, on rst=1 (immediately, asynchronously), set:
- state to IDLE;
- i_done and d_done to 0;
- inst_rdata and data_rdata to 0;
- mem_req to 0.
REQ-018 SHALL abandon any in-flight transaction on reset mid-operation. The shared memory is reset by the same rst.

Structure
REQ-019 SHALL take the FSM state encoding, the 32-bit address/data width constant and the 4-bit strobe width constant from the shared package cpu_bus_pkg.
REQ-020 SHALL be implemented as a single module with no sub-modules.

Verification
REQ-021 SHALL pass these directed scenarios:
- Fetch only: inst_req=1, inst_addr=0xBFC00000; memory returns addr_ok after 0 cycles, data_ok after 2 cycles with 0x3C1D0001 -> one mem_req, inst_rdata=0x3C1D0001, i_stall low the cycle after data_ok.
- Simultaneous: lw at 0x80001000 (rdata 0x12345678) and fetch at 0xBFC00004 -> data issued first, then fetch; longest_stall held until both are done; data_rdata=0x12345678.
- Byte store: data_wen=4'b0010, addr 0x80000002, wdata 0x0000AB00 -> mem_wr=1, mem_wstrb=4'b0010; data_rdata unchanged.
- Divide overlap: fetch completes while div_stall=1 for 10 cycles -> no second fetch issued; i_done cleared only after div_stall falls.
- Backpressure: mem_addr_ok held low for 5 cycles in D_REQ -> mem_addr and mem_wdata stable throughout.
- Reset asserted in I_WAIT -> state IDLE, all outputs 0 immediately; a stray mem_data_ok afterwards is ignored.
